// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and the serializer state encoding.
package uart_tx_pkg;

  // Word offsets, decoded from mem_addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head entry is visible
// on rdata whenever the FIFO is non-empty. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // count never exceeds DEPTH = 2**AW, so its MSB alone flags full
  assign full  = count[AW];
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers and count
  // define validity, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud
// counter and frame serializer.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_mask,
  input  logic        mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    word;
  logic          wr_en;
  logic          txdata_wr;
  logic          status_wr;
  logic          baud_wr;

  logic          overflow;
  logic [15:0]   baud_div;
  logic [15:0]   div_next;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_e     state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [15:0]   div_lat;
  logic [15:0]   baud_cnt;
  logic          bit_end;
  logic          frame_go;

  logic          unused;
  assign unused = ^{mem_addr[1:0], mem_wdata[31:16], mem_mask[3:2]};

  assign word      = mem_addr[3:2];
  assign wr_en     = io_sel & mem_wstrb;
  assign txdata_wr = wr_en && (word == REG_TXDATA) && mem_mask[0];
  assign status_wr = wr_en && (word == REG_STATUS);
  assign baud_wr   = wr_en && (word == REG_BAUDDIV);

  // Full is judged before any same-cycle pop, so a write to a full FIFO is
  // always dropped.
  assign fifo_push = txdata_wr & ~fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (mem_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
      baud_div <= BAUD_DIV_RESET;
    end else begin
      if (txdata_wr && fifo_full)
        overflow <= 1'b1;
      else if (status_wr && mem_mask[0] && mem_wdata[STAT_OVF])
        overflow <= 1'b0;
      if (baud_wr && mem_mask[0]) baud_div[7:0]  <= mem_wdata[7:0];
      if (baud_wr && mem_mask[1]) baud_div[15:8] <= mem_wdata[15:8];
    end
  end

  // A divider of 0 would never reach its terminal count; run it as 1.
  assign div_next = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign bit_end  = (baud_cnt == div_lat - 16'd1);

  // A frame starts from IDLE, or straight out of a finished STOP bit so
  // queued bytes go out with no idle gap.
  assign frame_go = ~fifo_empty &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign fifo_pop = frame_go;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      div_lat  <= 16'd1;
      baud_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_go) begin
            state    <= ST_START;
            tx       <= 1'b0;
            shift    <= fifo_rdata;
            div_lat  <= div_next;
            baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state    <= ST_DATA;
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= '0;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (frame_go) begin
              state   <= ST_START;
              tx      <= 1'b0;
              shift   <= fifo_rdata;
              div_lat <= div_next;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    mem_rdata = '0;
    if (io_sel) begin
      case (word)
        REG_STATUS: begin
          mem_rdata[STAT_BUSY]  = (state != ST_IDLE);
          mem_rdata[STAT_FULL]  = fifo_full;
          mem_rdata[STAT_EMPTY] = fifo_empty;
          mem_rdata[STAT_OVF]   = overflow;
          mem_rdata[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        end
        REG_BAUDDIV: mem_rdata[15:0] = baud_div;
        default:     mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a tx-line monitor checks every sample of
// each frame against a scoreboard of expected bytes and bit periods.
module tb_uart_tx_mmio;
  import uart_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_sel = 1'b0;
  logic [3:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_mask = '0;
  logic        mem_wstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk       (clk),
    .rst       (rst),
    .io_sel    (io_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mask  (mem_mask),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .tx        (tx)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
  } frame_t;

  frame_t sb[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // tx-line monitor: samples on the falling edge, one sample per clock
  int     cyc = 0;
  int     mon_frames = 0;
  int     last_end = -100;
  int     samp = 0;
  bit     mon_active = 1'b0;
  bit     mon_abort = 1'b0;
  frame_t cur;

  initial begin
    forever begin
      int   b;
      logic expb;
      @(negedge clk);
      cyc++;
      if (mon_abort) begin
        mon_active = 1'b0;
      end else if (!mon_active && tx === 1'b0) begin
        check("frame_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur        = sb.pop_front();
          mon_active = 1'b1;
          samp       = 0;
          if (cur.b2b) check($sformatf("frame_%0h_gap", cur.data), cyc, last_end + 1);
        end
      end
      if (mon_active && !mon_abort) begin
        b    = samp / cur.div;
        expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur.data[b-1];
        check($sformatf("frame_%0h_bit%0d", cur.data, b), tx, expb);
        samp++;
        if (samp == 10 * cur.div) begin
          mon_active = 1'b0;
          mon_frames++;
          last_end = cyc;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_write(input logic [1:0] word, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    io_sel    = 1'b1;
    mem_addr  = {word, 2'b00};
    mem_wdata = data;
    mem_mask  = mask;
    mem_wstrb = 1'b1;
    @(posedge clk);
    #1;
    io_sel    = 1'b0;
    mem_wstrb = 1'b0;
    mem_mask  = '0;
  endtask

  task automatic bus_read(input logic [1:0] word, output logic [31:0] data);
    io_sel    = 1'b1;
    mem_addr  = {word, 2'b00};
    mem_wstrb = 1'b0;
    #1;
    data   = mem_rdata;
    io_sel = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int div, input bit b2b, input bit accept);
    frame_t f;
    f.data = b;
    f.div  = div;
    f.b2b  = b2b;
    if (accept) sb.push_back(f);
    bus_write(REG_TXDATA, {24'h0, b}, 4'b0001);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (mon_frames < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frames_done", mon_frames, target);
  endtask

  initial begin
    logic [31:0] rd;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("tx_in_reset", tx, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_read(REG_STATUS, rd);  check("status_reset", rd, 32'h4);
    bus_read(REG_BAUDDIV, rd); check("bauddiv_reset", rd, 32'd104);
    bus_read(REG_TXDATA, rd);  check("txdata_reads_zero", rd, 32'h0);
    bus_read(REG_RSVD, rd);    check("reserved_reads_zero", rd, 32'h0);
    check("tx_idle_after_reset", tx, 1);

    // Single frame at div=4, tx falls one cycle after the push
    bus_write(REG_BAUDDIV, 32'h0000_0004, 4'b0011);
    bus_read(REG_BAUDDIV, rd); check("bauddiv_4", rd, 32'h4);
    push_byte(8'hA5, 4, 1'b0, 1'b1);
    bus_read(REG_STATUS, rd);  check("status_after_push", rd, 32'h100);
    check("tx_high_at_push_edge", tx, 1);
    @(posedge clk);
    #1;
    check("tx_falls_next_edge", tx, 0);
    bus_read(REG_STATUS, rd);  check("status_frame_started", rd, 32'h5);
    wait_frames(1, 100);
    repeat (2) @(posedge clk);
    #1;
    bus_read(REG_STATUS, rd);  check("status_idle_after_frame", rd, 32'h4);

    // Nine back-to-back pushes, then three dropped on a full FIFO
    push_byte(8'h01, 4, 1'b0, 1'b1);
    for (int i = 2; i <= 9; i++) push_byte(8'(i * 17), 4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push_byte(8'hEE, 4, 1'b0, 1'b0);
    bus_read(REG_STATUS, rd);  check("status_full_overflow", rd, 32'h80B);

    // Clearing overflow leaves the other STATUS bits alone
    bus_write(REG_STATUS, 32'h0000_0008, 4'b0001);
    bus_read(REG_STATUS, rd);  check("status_overflow_cleared", rd, 32'h803);
    wait_frames(10, 600);

    // Divider change mid-frame applies from the next frame
    repeat (2) @(posedge clk);
    #1;
    push_byte(8'h3C, 4, 1'b0, 1'b1);
    push_byte(8'hC3, 2, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bus_write(REG_BAUDDIV, 32'h0000_0002, 4'b0011);
    bus_read(REG_BAUDDIV, rd); check("bauddiv_2", rd, 32'h2);
    wait_frames(12, 400);
    bus_write(REG_BAUDDIV, 32'h0000_1234, 4'b0010);
    bus_read(REG_BAUDDIV, rd); check("bauddiv_lane1_only", rd, 32'h1202);
    bus_write(REG_BAUDDIV, 32'h0000_0000, 4'b0011);
    bus_read(REG_BAUDDIV, rd); check("bauddiv_0", rd, 32'h0);
    push_byte(8'h5A, 1, 1'b0, 1'b1);
    wait_frames(13, 100);

    // Reset during DATA bit 3 discards the frame and the queue
    repeat (3) @(posedge clk);
    #1;
    bus_write(REG_BAUDDIV, 32'h0000_0004, 4'b0011);
    push_byte(8'h96, 4, 1'b0, 1'b1);
    push_byte(8'h11, 4, 1'b1, 1'b1);
    push_byte(8'h22, 4, 1'b1, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    rst       = 1'b0;
    mon_abort = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    check("tx_high_after_midframe_reset", tx, 1);
    bus_read(REG_STATUS, rd);  check("status_after_midframe_reset", rd, 32'h4);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mon_abort = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("no_frame_after_reset", mon_frames, 13);
    check("tx_idle_after_reset_gap", tx, 1);
    bus_read(REG_BAUDDIV, rd); check("bauddiv_back_to_reset", rd, 32'd104);

    // Unselected write must not push, and reads return 0
    @(negedge clk);
    io_sel    = 1'b0;
    mem_addr  = 4'h0;
    mem_wdata = 32'h0000_0077;
    mem_mask  = 4'hF;
    mem_wstrb = 1'b1;
    #1;
    check("rdata_unselected_txdata", mem_rdata, 32'h0);
    mem_addr = 4'h4;
    #1;
    check("rdata_unselected_status", mem_rdata, 32'h0);
    mem_addr = 4'h0;
    @(posedge clk);
    #1;
    mem_wstrb = 1'b0;
    mem_mask  = '0;
    bus_read(REG_STATUS, rd);  check("no_push_unselected", rd, 32'h4);
    repeat (20) @(posedge clk);
    #1;
    check("tx_idle_final", tx, 1);
    check("no_extra_frames", mon_frames, 13);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
